// File: rtl/lis_data_mem_pkg.sv
// Shared opcode encodings, widths, FSM states and request record for lis_data_mem.
package lis_data_mem_pkg;

    localparam int LIS_OP_WIDTH   = 3;
    localparam int DATA_WIDTH     = 32;
    localparam int REG_DATA_WIDTH = DATA_WIDTH;
    localparam int MEM_ADDR_WIDTH = 10;
    localparam int RAM_ADDR_WIDTH = MEM_ADDR_WIDTH - 2;

    typedef logic [LIS_OP_WIDTH-1:0] lis_op_t;

    localparam lis_op_t LIS_LB  = 3'd0;
    localparam lis_op_t LIS_LH  = 3'd1;
    localparam lis_op_t LIS_LW  = 3'd2;
    localparam lis_op_t LIS_LBU = 3'd3;
    localparam lis_op_t LIS_LHU = 3'd4;
    localparam lis_op_t LIS_SB  = 3'd5;
    localparam lis_op_t LIS_SH  = 3'd6;
    localparam lis_op_t LIS_SW  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    typedef struct packed {
        lis_op_t                   op;
        logic [MEM_ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]     wdata;
    } req_t;

    function automatic logic is_misaligned(lis_op_t op, logic [1:0] lo);
        case (op)
            LIS_LH, LIS_LHU, LIS_SH: is_misaligned = lo[0];
            LIS_LW, LIS_SW:          is_misaligned = (lo != 2'b00);
            default:                 is_misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic is_sub_store(lis_op_t op);
        is_sub_store = (op == LIS_SB) || (op == LIS_SH);
    endfunction

endpackage

// File: rtl/lis_data_mem_data_ram_sp.sv
// Word-wide single-port RAM, no byte enables.
// Latency: registered read, data valid the cycle after the address.
// Backpressure: none, accepts a read or write every cycle.
module data_ram_sp
    import lis_data_mem_pkg::*;
(
    input  logic                      clk,
    input  logic                      we,
    input  logic [RAM_ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0]     wdata,
    output logic [DATA_WIDTH-1:0]     rdata
);

    localparam int DEPTH = 1 << RAM_ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/lis_data_mem.sv
// Load/store responder: byte-addressed requests onto a word RAM, sub-word stores by read-modify-write.
// Latency: SW and misaligned respond one cycle after accept; loads, SB, SH two cycles.
// Backpressure: req_ready_o high only in IDLE; one request in flight, no response backpressure.
module lis_data_mem
    import lis_data_mem_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [LIS_OP_WIDTH-1:0]   LIS_op_i,
    input  logic [MEM_ADDR_WIDTH-1:0] addr_mem_i,
    input  logic [DATA_WIDTH-1:0]     val_mem_write_i,
    output logic                      rsp_valid_o,
    output logic                      rsp_err_o,
    output logic [DATA_WIDTH-1:0]     val_mem_read_o
);

    state_t                    state_q, state_d;
    req_t                      req_q, req_d;
    logic                      err_q, err_d;
    logic [DATA_WIDTH-1:0]     rd_data_q, rd_data_d;
    logic                      ram_we;
    logic [RAM_ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0]     ram_wdata, ram_rdata;
    logic                      accept;

    // Load data comes back lane-shifted and unextended; sign handling is the core's job.
    function automatic logic [DATA_WIDTH-1:0] lane_extract(lis_op_t op, logic [1:0] off,
                                                           logic [DATA_WIDTH-1:0] word);
        logic [DATA_WIDTH-1:0] sh;
        case (op)
            LIS_LB, LIS_LBU: begin
                sh = word >> {off, 3'b000};
                lane_extract = {24'd0, sh[7:0]};
            end
            LIS_LH, LIS_LHU: begin
                sh = word >> {off[1], 4'b0000};
                lane_extract = {16'd0, sh[15:0]};
            end
            default: begin
                sh = word;
                lane_extract = word;
            end
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] lane_merge(lis_op_t op, logic [1:0] off,
                                                         logic [DATA_WIDTH-1:0] word,
                                                         logic [DATA_WIDTH-1:0] wd);
        lane_merge = word;
        if (op == LIS_SB) begin
            lane_merge[{off, 3'b000} +: 8] = wd[7:0];
        end else if (op == LIS_SH) begin
            lane_merge[{off[1], 4'b0000} +: 16] = wd[15:0];
        end
    endfunction

    assign accept = req_valid_i && (state_q == ST_IDLE);

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        err_d     = err_q;
        rd_data_d = rd_data_q;
        ram_we    = 1'b0;
        ram_addr  = addr_mem_i[MEM_ADDR_WIDTH-1:2];
        ram_wdata = val_mem_write_i;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    req_d = '{op: LIS_op_i, addr: addr_mem_i, wdata: val_mem_write_i};
                    err_d = 1'b0;
                    if (is_misaligned(LIS_op_i, addr_mem_i[1:0])) begin
                        err_d     = 1'b1;
                        rd_data_d = '0;
                        state_d   = ST_RSP;
                    end else if (LIS_op_i == LIS_SW) begin
                        ram_we  = 1'b1;
                        state_d = ST_RSP;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                ram_addr = req_q.addr[MEM_ADDR_WIDTH-1:2];
                if (is_sub_store(req_q.op)) begin
                    ram_we    = 1'b1;
                    ram_wdata = lane_merge(req_q.op, req_q.addr[1:0], ram_rdata, req_q.wdata);
                end else begin
                    rd_data_d = lane_extract(req_q.op, req_q.addr[1:0], ram_rdata);
                end
                state_d = ST_RSP;
            end
            ST_RSP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // A reset edge must not commit a pending merged write.
        if (rst) begin
            ram_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            req_q     <= '0;
            err_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            err_q     <= err_d;
            rd_data_q <= rd_data_d;
        end
    end

    data_ram_sp u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign req_ready_o    = (state_q == ST_IDLE);
    assign rsp_valid_o    = (state_q == ST_RSP) && !rst;
    assign rsp_err_o      = rsp_valid_o && err_q;
    assign val_mem_read_o = rd_data_q;

endmodule
